// File: rtl/seg_scan_mux.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Double-buffered digit bank, dark gap at the start of each slot, optional leading-zero blanking.
module seg_scan_mux #(
   parameter int unsigned NDIG      = 4,
   parameter int unsigned TICK_DIV  = 50000,
   parameter int unsigned BLANK_CYC = 500
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [$clog2(NDIG)-1:0] wr_addr,
   input  logic [4:0]              wr_code,
   input  logic                    wr_dp,
   input  logic                    lzb,
   output logic [4:0]              code,
   output logic                    dp,
   output logic [NDIG-1:0]         dig_sel,
   output logic                    frame
);

   localparam int unsigned AW = $clog2(NDIG);
   localparam int unsigned CW = $clog2(TICK_DIV);

   localparam logic [CW-1:0]   CNT_LAST   = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0]   CNT_ACT    = CW'(BLANK_CYC);
   localparam logic [AW-1:0]   IDX_LAST   = AW'(NDIG - 1);
   localparam logic [4:0]      CODE_BLANK = 5'd31;
   localparam logic [NDIG-1:0] SEL_ONE    = NDIG'(1);

   typedef enum logic {StBlank, StActive} state_e;

   state_e         state;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic [AW-1:0]  idx, idx_nxt;
   logic [4:0]     shadow_code [NDIG];
   logic           shadow_dp   [NDIG];
   logic [4:0]     disp_code   [NDIG];
   logic           disp_dp     [NDIG];
   logic [NDIG-1:0] lz_blank;
   logic           lz_run;
   logic           slot_end, wrap;
   logic [4:0]     eff_code;
   logic           eff_dp;

   always_comb begin
      slot_end = (cnt == CNT_LAST);
      wrap     = slot_end && (idx == IDX_LAST);
      cnt_nxt  = slot_end ? '0 : cnt + 1'b1;
      idx_nxt  = idx;
      if (slot_end) begin
         idx_nxt = wrap ? '0 : idx + 1'b1;
      end
   end

   // A blanking run starts at the MSB and stops at the first nonzero code or set dp.
   always_comb begin
      lz_blank = '0;
      lz_run   = lzb;
      for (int i = int'(NDIG) - 1; i > 0; i--) begin
         lz_run      = lz_run && (disp_code[i] == 5'd0) && !disp_dp[i];
         lz_blank[i] = lz_run;
      end
   end

   always_comb begin
      eff_code = lz_blank[idx] ? CODE_BLANK : disp_code[idx];
      eff_dp   = lz_blank[idx] ? 1'b0 : disp_dp[idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= StBlank;
         cnt     <= '0;
         idx     <= '0;
         code    <= CODE_BLANK;
         dp      <= 1'b0;
         dig_sel <= '1;
         frame   <= 1'b0;
         for (int i = 0; i < int'(NDIG); i++) begin
            shadow_code[i] <= CODE_BLANK;
            shadow_dp[i]   <= 1'b0;
            disp_code[i]   <= CODE_BLANK;
            disp_dp[i]     <= 1'b0;
         end
      end else begin
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         frame <= wrap;
         for (int i = 0; i < int'(NDIG); i++) begin
            if (wr_en && (wr_addr == AW'(i))) begin
               shadow_code[i] <= wr_code;
               shadow_dp[i]   <= wr_dp;
            end
            // Display takes the pre-edge shadow, so a same-edge write waits a frame.
            if (wrap) begin
               disp_code[i] <= shadow_code[i];
               disp_dp[i]   <= shadow_dp[i];
            end
         end
         unique case (state)
            StBlank: begin
               if (cnt_nxt == CNT_ACT) begin
                  state   <= StActive;
                  dig_sel <= ~(SEL_ONE << idx);
                  code    <= eff_code;
                  dp      <= eff_dp;
               end
            end
            StActive: begin
               if (slot_end) begin
                  state   <= StBlank;
                  dig_sel <= '1;
                  code    <= CODE_BLANK;
                  dp      <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: expected digit values are queued as data is written and
// popped as each ACTIVE window appears.
module tb_seg_scan_mux;

   localparam int unsigned NDIG = 4;
   localparam int unsigned TICK = 8;
   localparam int unsigned BLK  = 2;

   logic       clk = 1'b0;
   logic       rst, wr_en, wr_dp, lzb, wr_en3;
   logic [1:0] wr_addr, wr_addr3;
   logic [4:0] wr_code;
   logic [4:0] code, code3;
   logic       dp, dp3, frame, frame3;
   logic [3:0] dig_sel;
   logic [2:0] dig_sel3;

   int         n_assert = 0;
   int         n_fail   = 0;
   int         n;
   logic [5:0] exp_q[$];

   seg_scan_mux #(.NDIG(NDIG), .TICK_DIV(TICK), .BLANK_CYC(BLK)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_code(wr_code),
      .wr_dp(wr_dp), .lzb(lzb), .code(code), .dp(dp), .dig_sel(dig_sel), .frame(frame)
   );

   seg_scan_mux #(.NDIG(3), .TICK_DIV(TICK), .BLANK_CYC(BLK)) dut3 (
      .clk(clk), .rst(rst), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_code(wr_code),
      .wr_dp(wr_dp), .lzb(lzb), .code(code3), .dp(dp3), .dig_sel(dig_sel3), .frame(frame3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [4:0] c, input logic d);
      wr_en = 1'b1; wr_addr = a; wr_code = c; wr_dp = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wr3(input logic [1:0] a, input logic [4:0] c, input logic d);
      wr_en3 = 1'b1; wr_addr3 = a; wr_code = c; wr_dp = d;
      @(negedge clk);
      wr_en3 = 1'b0;
   endtask

   task automatic push(input logic [4:0] c, input logic d);
      exp_q.push_back({c, d});
   endtask

   task automatic wait_frame(input bit use3, output int cnt);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!(use3 ? frame3 : frame) && cnt < 200);
      chk("frame_seen", 8'(use3 ? frame3 : frame), 8'd1);
   endtask

   // Called at the negedge where frame is high; walks the 32 cycles of that frame.
   task automatic check_frame(input int wcyc, input logic [1:0] wa, input logic [4:0] wc);
      logic [5:0] e;
      logic [3:0] sel;
      int         slot, off;
      e = {5'd31, 1'b0};
      for (int c = 0; c < int'(NDIG * TICK); c++) begin
         slot = c / int'(TICK);
         off  = c % int'(TICK);
         if (c == wcyc) begin
            wr_en = 1'b1; wr_addr = wa; wr_code = wc; wr_dp = 1'b0;
         end else begin
            wr_en = 1'b0;
         end
         if (off == int'(BLK)) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = {5'd31, 1'b0};
         end
         sel = (off < int'(BLK)) ? 4'hF : ~(4'b0001 << slot);
         chk("dig_sel", 8'(dig_sel), 8'(sel));
         chk("frame", 8'(frame), 8'(c == 0));
         chk("code", 8'(code), (off < int'(BLK)) ? 8'd31 : 8'(e[5:1]));
         chk("dp", 8'(dp), (off < int'(BLK)) ? 8'd0 : 8'(e[0]));
         if (c < int'(NDIG * TICK) - 1) @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_code = '0; wr_dp = 1'b0; lzb = 1'b0;
      wr_en3 = 1'b0; wr_addr3 = '0;

      // Reset and release
      repeat (3) @(negedge clk);
      chk("rst_sel", 8'(dig_sel), 8'hF);
      chk("rst_code", 8'(code), 8'd31);
      chk("rst_dp", 8'(dp), 8'd0);
      chk("rst_frame", 8'(frame), 8'd0);
      rst = 1'b0;
      for (int i = 0; i < int'(BLK) - 1; i++) begin
         @(negedge clk);
         chk("post_rst_blank", 8'(dig_sel), 8'hF);
      end
      @(negedge clk);
      chk("first_active_sel", 8'(dig_sel), 8'hE);
      chk("first_active_code", 8'(code), 8'd31);

      // Scan timing
      wr(2'd3, 5'h1, 1'b0);
      wr(2'd2, 5'h2, 1'b0);
      wr(2'd1, 5'h3, 1'b0);
      wr(2'd0, 5'h4, 1'b0);
      wait_frame(1'b0, n);
      chk("first_period", 8'(n), 8'd26);
      push(5'h4, 1'b0); push(5'h3, 1'b0); push(5'h2, 1'b0); push(5'h1, 1'b0);
      check_frame(-1, 2'd0, 5'd0);

      // Double buffering: write on the wrap edge, then one mid-frame
      wr_en = 1'b1; wr_addr = 2'd0; wr_code = 5'hA; wr_dp = 1'b0;
      wait_frame(1'b0, n);
      wr_en = 1'b0;
      chk("period", 8'(n), 8'd1);
      push(5'h4, 1'b0); push(5'h3, 1'b0); push(5'h2, 1'b0); push(5'h1, 1'b0);
      check_frame(4, 2'd1, 5'h7);
      wait_frame(1'b0, n);
      push(5'hA, 1'b0); push(5'h7, 1'b0); push(5'h2, 1'b0); push(5'h1, 1'b0);
      check_frame(-1, 2'd0, 5'd0);

      // Leading-zero blanking
      lzb = 1'b1;
      wr(2'd3, 5'h0, 1'b0);
      wr(2'd2, 5'h0, 1'b0);
      wr(2'd1, 5'h5, 1'b0);
      wr(2'd0, 5'h0, 1'b0);
      wait_frame(1'b0, n);
      push(5'h0, 1'b0); push(5'h5, 1'b0); push(5'd31, 1'b0); push(5'd31, 1'b0);
      check_frame(-1, 2'd0, 5'd0);

      wr(2'd3, 5'h0, 1'b1);
      wait_frame(1'b0, n);
      push(5'h0, 1'b0); push(5'h5, 1'b0); push(5'h0, 1'b0); push(5'h0, 1'b1);
      check_frame(-1, 2'd0, 5'd0);

      lzb = 1'b0;
      wr(2'd3, 5'h0, 1'b0);
      wait_frame(1'b0, n);
      push(5'h0, 1'b0); push(5'h5, 1'b0); push(5'h0, 1'b0); push(5'h0, 1'b0);
      check_frame(-1, 2'd0, 5'd0);

      lzb = 1'b1;
      wr(2'd1, 5'h0, 1'b0);
      wait_frame(1'b0, n);
      push(5'h0, 1'b0); push(5'd31, 1'b0); push(5'd31, 1'b0); push(5'd31, 1'b0);
      check_frame(-1, 2'd0, 5'd0);

      // Reset during ACTIVE of digit 2, with a pending shadow write
      lzb = 1'b0;
      wait_frame(1'b0, n);
      wr(2'd2, 5'h9, 1'b1);
      repeat (17) @(negedge clk);
      chk("pre_rst_sel", 8'(dig_sel), 8'hB);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_sel", 8'(dig_sel), 8'hF);
      chk("mid_rst_code", 8'(code), 8'd31);
      chk("mid_rst_dp", 8'(dp), 8'd0);
      chk("mid_rst_frame", 8'(frame), 8'd0);
      rst = 1'b0;
      repeat (BLK) @(negedge clk);
      chk("rst_idx0_sel", 8'(dig_sel), 8'hE);
      chk("rst_idx0_code", 8'(code), 8'd31);
      wait_frame(1'b0, n);
      chk("rst_period", 8'(n), 8'd30);
      for (int i = 0; i < int'(NDIG); i++) push(5'd31, 1'b0);
      check_frame(-1, 2'd0, 5'd0);

      // Out-of-range address on a 3-digit instance
      wr3(2'd0, 5'h1, 1'b0);
      wr3(2'd1, 5'h2, 1'b0);
      wr3(2'd2, 5'h3, 1'b0);
      wr3(2'd3, 5'h9, 1'b1);
      wait_frame(1'b1, n);
      for (int c = 1; c < 3 * int'(TICK); c++) begin
         @(negedge clk);
         if (c % int'(TICK) == 4) begin
            chk("oor_code", 8'(code3), 8'(c / int'(TICK) + 1));
            chk("oor_dp", 8'(dp3), 8'd0);
            chk("oor_sel", 8'(dig_sel3), 8'(3'b111 & ~(3'b001 << (c / int'(TICK)))));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
